// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types and sizes for the CPU memory port-A arbiter.
// Mirrors the CHIP-8 system defines: address/data widths, FSM states, requester IDs.
package cpu_mem_arbiter_pkg;

    localparam int CHIP8_ADDR_W = 12;
    localparam int CHIP8_DATA_W = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } arb_state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_t;

endpackage

// File: rtl/cpu_mem_arb_pick.sv
// Combinational two-way winner select for the port-A arbiter.
// Define CPU_MEM_ARB_RR_EN for round-robin ties; otherwise the CPU always wins ties.
module cpu_mem_arb_pick
    import cpu_mem_arbiter_pkg::*;
(
    input  logic    cpu_req,
    input  logic    dma_req,
`ifdef CPU_MEM_ARB_RR_EN
    input  req_id_t last_gnt,
`endif
    output logic    any_req,
    output req_id_t winner
);

    // NOTE: every output gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        any_req = cpu_req | dma_req;
        winner  = REQ_CPU;
        if (cpu_req && dma_req) begin
`ifdef CPU_MEM_ARB_RR_EN
            winner = (last_gnt == REQ_CPU) ? REQ_DMA : REQ_CPU;
`else
            winner = REQ_CPU;
`endif
        end else if (dma_req) begin
            winner = REQ_DMA;
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Serialises CPU and DMA/loader accesses onto RAM port A: one access per two clocks.
// Tie policy selected by CPU_MEM_ARB_RR_EN (round-robin) or fixed CPU priority when undefined.
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = CHIP8_ADDR_W,
    parameter int DATA_W = CHIP8_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_write,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_t        state, state_n;
    req_id_t           gnt_id, gnt_id_n;
    logic              mem_en_n, mem_write_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_n;
    logic              cpu_ack_n, dma_ack_n;
    logic              any_req;
    req_id_t           winner;

`ifdef CPU_MEM_ARB_RR_EN
    req_id_t           last_gnt, last_gnt_n;
`endif

    cpu_mem_arb_pick u_pick (
        .cpu_req  (cpu_req),
        .dma_req  (dma_req),
`ifdef CPU_MEM_ARB_RR_EN
        .last_gnt (last_gnt),
`endif
        .any_req  (any_req),
        .winner   (winner)
    );

    always_comb begin
        state_n     = state;
        gnt_id_n    = gnt_id;
        mem_en_n    = 1'b0;
        mem_write_n = 1'b0;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        cpu_ack_n   = 1'b0;
        dma_ack_n   = 1'b0;
`ifdef CPU_MEM_ARB_RR_EN
        last_gnt_n  = last_gnt;
`endif
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_n  = ST_ACCESS;
                    gnt_id_n = winner;
                    mem_en_n = 1'b1;
`ifdef CPU_MEM_ARB_RR_EN
                    last_gnt_n = winner;
`endif
                    if (winner == REQ_DMA) begin
                        mem_write_n = dma_write;
                        mem_addr_n  = dma_addr;
                        mem_wdata_n = dma_wdata;
                    end else begin
                        mem_write_n = cpu_write;
                        mem_addr_n  = cpu_addr;
                        mem_wdata_n = cpu_wdata;
                    end
                end
            end
            // RAM samples the registered command on this edge; ack lines up with its registered read data.
            ST_ACCESS: begin
                state_n   = ST_IDLE;
                cpu_ack_n = (gnt_id == REQ_CPU);
                dma_ack_n = (gnt_id == REQ_DMA);
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            gnt_id    <= REQ_CPU;
            mem_en    <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
`ifdef CPU_MEM_ARB_RR_EN
            last_gnt  <= REQ_DMA;
`endif
        end else begin
            state     <= state_n;
            gnt_id    <= gnt_id_n;
            mem_en    <= mem_en_n;
            mem_write <= mem_write_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            cpu_ack   <= cpu_ack_n;
            dma_ack   <= dma_ack_n;
`ifdef CPU_MEM_ARB_RR_EN
            last_gnt  <= last_gnt_n;
`endif
        end
    end

    assign busy      = (state == ST_ACCESS);
    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Scoreboard bench for cpu_mem_arbiter with a behavioural RAM and reference memory.
// Honours CPU_MEM_ARB_RR_EN for the continuous-contention ordering.
module tb_cpu_mem_arbiter;
    import cpu_mem_arbiter_pkg::*;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_write, dma_req, dma_write;
    logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata, mem_wdata, mem_rdata;
    logic [DW-1:0] cpu_rdata, dma_rdata;
    logic          cpu_ack, dma_ack, mem_en, mem_write, busy;

    always #5 clk = ~clk;

    cpu_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .dma_req   (dma_req),
        .dma_write (dma_write),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_ack   (dma_ack),
        .dma_rdata (dma_rdata),
        .mem_en    (mem_en),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Power-up RAM contents: a fixed function of the address (0x200 holds 0x12).
    function automatic logic [7:0] init_val(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h30;
    endfunction

    // Behavioural single-port RAM with registered read data.
    logic [7:0] ram    [4096];
    bit         ram_wr [4096];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_write) begin
                ram[mem_addr]    <= mem_wdata;
                ram_wr[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
            end
        end
    end

    typedef struct {
        req_id_t    id;
        logic       is_read;
        logic [7:0] data;
    } exp_t;

    logic [7:0] ref_mem [int];
    exp_t       sb_q [$];
    int         total = 0;
    int         bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: accesses complete in issue order, reads return the latest committed byte.
    function automatic void expect_access(input req_id_t id, input logic wr,
                                          input logic [11:0] a, input logic [7:0] d);
        exp_t e;
        e.id      = id;
        e.is_read = !wr;
        e.data    = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
        if (wr) ref_mem[int'(a)] = d;
        sb_q.push_back(e);
    endfunction

    // Monitor: every ack pops one expected completion.
    always @(negedge clk) begin
        exp_t e;
        if (cpu_ack || dma_ack) begin
            check("ack_overlap", 32'(cpu_ack & dma_ack), 32'd0);
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: cpu_ack=%0b dma_ack=%0b at %0t", cpu_ack, dma_ack, $time);
            end else begin
                e = sb_q.pop_front();
                check("ack_id", 32'(dma_ack), 32'(e.id));
                if (e.is_read)
                    check("rdata", 32'(dma_ack ? dma_rdata : cpu_rdata), 32'(e.data));
            end
        end
    end

    task automatic drive(input req_id_t id, input logic rq, input logic wr,
                         input logic [11:0] a, input logic [7:0] d);
        if (id == REQ_CPU) begin
            cpu_req = rq; cpu_write = wr; cpu_addr = a; cpu_wdata = d;
        end else begin
            dma_req = rq; dma_write = wr; dma_addr = a; dma_wdata = d;
        end
    endtask

    // Issue one request, wait (bounded) for its ack, check latency, release.
    task automatic do_access(input req_id_t id, input logic wr, input logic [11:0] a,
                             input logic [7:0] d, input int exp_lat, input bit scramble);
        int   lat = 0;
        logic got;
        drive(id, 1'b1, wr, a, d);
        do begin
            @(negedge clk);
            lat++;
            got = (id == REQ_CPU) ? cpu_ack : dma_ack;
            if (lat == 1 && scramble && !got)
                drive(id, 1'b1, 1'($urandom), 12'($urandom), 8'($urandom));
        end while (!got && lat < 20);
        check($sformatf("latency_%s", id.name()), 32'(lat), 32'(exp_lat));
        drive(id, 1'b0, 1'b0, 12'h000, 8'h00);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_en"},    32'(mem_en),    32'd0);
        check({tag, "_mem_write"}, 32'(mem_write), 32'd0);
        check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_cpu_ack"},   32'(cpu_ack),   32'd0);
        check({tag, "_dma_ack"},   32'(dma_ack),   32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int acks;
        logic [11:0] a;
        req_id_t id;
        logic wr;

        reset = 1'b1;
        drive(REQ_CPU, 1'b0, 1'b0, 12'h000, 8'h00);
        drive(REQ_DMA, 1'b0, 1'b0, 12'h000, 8'h00);
        #1 check_all_zero("por");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // CPU read of 0x200: command registered after edge 0, ack+data after edge 1.
        expect_access(REQ_CPU, 1'b0, 12'h200, 8'h00);
        drive(REQ_CPU, 1'b1, 1'b0, 12'h200, 8'h00);
        @(posedge clk); #1;
        check("rd200_mem_en",   32'(mem_en),    32'd1);
        check("rd200_mem_addr", 32'(mem_addr),  32'h200);
        check("rd200_mem_wr",   32'(mem_write), 32'd0);
        check("rd200_busy",     32'(busy),      32'd1);
        check("rd200_no_ack",   32'(cpu_ack),   32'd0);
        @(posedge clk); #1;
        check("rd200_ack",      32'(cpu_ack),   32'd1);
        check("rd200_rdata",    32'(cpu_rdata), 32'h12);
        check("rd200_mem_en0",  32'(mem_en),    32'd0);
        check("rd200_busy0",    32'(busy),      32'd0);
        @(negedge clk);
        drive(REQ_CPU, 1'b0, 1'b0, 12'h000, 8'h00);

        // DMA write then CPU readback.
        expect_access(REQ_DMA, 1'b1, 12'h300, 8'hA5);
        do_access(REQ_DMA, 1'b1, 12'h300, 8'hA5, 2, 1'b0);
        expect_access(REQ_CPU, 1'b0, 12'h300, 8'h00);
        do_access(REQ_CPU, 1'b0, 12'h300, 8'h00, 2, 1'b0);

        // Simultaneous single-shot reads: CPU wins (last grant is DMA after reset), DMA follows.
        apply_reset();
        expect_access(REQ_CPU, 1'b0, 12'h200, 8'h00);
        expect_access(REQ_DMA, 1'b0, 12'h300, 8'h00);
        fork
            do_access(REQ_CPU, 1'b0, 12'h200, 8'h00, 2, 1'b0);
            do_access(REQ_DMA, 1'b0, 12'h300, 8'h00, 4, 1'b0);
        join

        // Both requests held continuously for four accesses.
        apply_reset();
        for (int i = 0; i < 4; i++) begin
`ifdef CPU_MEM_ARB_RR_EN
            if (i % 2 == 0) expect_access(REQ_CPU, 1'b0, 12'h210, 8'h00);
            else            expect_access(REQ_DMA, 1'b0, 12'h320, 8'h00);
`else
            expect_access(REQ_CPU, 1'b0, 12'h210, 8'h00);
`endif
        end
        drive(REQ_CPU, 1'b1, 1'b0, 12'h210, 8'h00);
        drive(REQ_DMA, 1'b1, 1'b0, 12'h320, 8'h00);
        acks = 0;
        for (int c = 0; c < 30 && acks < 4; c++) begin
            @(negedge clk);
            if (cpu_ack || dma_ack) acks++;
        end
        drive(REQ_CPU, 1'b0, 1'b0, 12'h000, 8'h00);
        drive(REQ_DMA, 1'b0, 1'b0, 12'h000, 8'h00);
        check("held_ack_count", 32'(acks), 32'd4);

        // Reset during the ACCESS cycle of a CPU write: no ack, then reissue.
        drive(REQ_CPU, 1'b1, 1'b1, 12'h400, 8'h7E);
        @(posedge clk); #1;
        check("rst_mid_busy",   32'(busy),     32'd1);
        check("rst_mid_mem_en", 32'(mem_en),   32'd1);
        check("rst_mid_addr",   32'(mem_addr), 32'h400);
        #1 reset = 1'b1;
        #1 check_all_zero("async_rst");
        drive(REQ_CPU, 1'b0, 1'b0, 12'h000, 8'h00);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_no_ack", 32'(cpu_ack | dma_ack), 32'd0);
        end
        reset = 1'b0;
        expect_access(REQ_CPU, 1'b1, 12'h400, 8'h7E);
        do_access(REQ_CPU, 1'b1, 12'h400, 8'h7E, 2, 1'b0);
        expect_access(REQ_CPU, 1'b0, 12'h400, 8'h00);
        do_access(REQ_CPU, 1'b0, 12'h400, 8'h00, 2, 1'b0);

        // Randomised single-requester traffic; inputs are scrambled while ACCESS is in progress.
        for (int i = 0; i < 60; i++) begin
            id = $urandom_range(0, 1) ? REQ_DMA : REQ_CPU;
            wr = 1'($urandom);
            a  = $urandom_range(0, 1) ? {8'h50, 4'($urandom)} : 12'($urandom);
            begin
                logic [7:0] d;
                d = 8'($urandom);
                expect_access(id, wr, a, d);
                do_access(id, wr, a, d, 2, 1'b1);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
